math_round_sequencer: RTL
=========================

// Module: math_round_sequencer
// PURPOSE
//  Round controller for the math game. Sequences the three load_register instances
//  (operand A, operand B, player answer) through each question.
//  Checks the answer, keeps score and round count, and ends the game after ROUNDS questions.
//  Sits between the debounced buttons / LFSR and the operand registers plus display logic.
// PARAMETERS
//  DATA_W      4    width of operands and answer; must match the load_register width
//  SCORE_W     4    width of the saturating score counter
//  ROUNDS      8    questions per game (2..2**ROUND_W)
//  ROUND_W     3    width of the round counter
//  RESULT_CYC  50   cycles result_valid is held (display window, >=1)
//  TIMEOUT_CYC 1000 answer window in cycles (used only with ROUND_TIMEOUT_EN)
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous, active-low reset
//  start        in   1        1-cycle pulse: begin a new game
//  enter        in   1        1-cycle pulse: player submits the answer
//  a_q          in   DATA_W   operand A register output
//  b_q          in   DATA_W   operand B register output
//  ans_q        in   DATA_W   answer register output
//  load_a       out  1        load strobe, operand A register
//  load_b       out  1        load strobe, operand B register
//  load_ans     out  1        load strobe, answer register
//  result_valid out  1        correct/timed_out are valid
//  correct      out  1        last answer was right
//  timed_out    out  1        last round expired with no answer
//  score        out  SCORE_W  correct answers this game
//  round        out  ROUND_W  current round index, 0-based
//  busy         out  1        game in progress (not IDLE/DONE)
//  game_over    out  1        all rounds finished
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE; every output 0; internal counters 0.
//    Reset mid-game aborts the round immediately; no load strobe fires on that edge.
//  - All outputs are registered; load_* are single-cycle and mutually exclusive.
//  - IDLE: start -> LOAD_A; clears score, round, correct and timed_out.
//  - LOAD_A: load_a=1 for 1 cycle -> LOAD_B.
//  - LOAD_B: load_b=1 for 1 cycle -> WAIT_ANS; answer timer cleared to 0.
//  - WAIT_ANS: enter -> LOAD_ANS.
//    If the timer reaches TIMEOUT_CYC-1 -> RESULT with timed_out=1, correct=0.
//    If enter and timeout occur in the same cycle, enter wins.
//  - LOAD_ANS: load_ans=1 for 1 cycle -> CHECK. ans_q is valid from CHECK onward.
//  - CHECK: correct <= ((a_q+b_q) mod 2**DATA_W) == ans_q; timed_out <= 0.
//    If correct, score += 1, saturating at 2**SCORE_W-1. Then -> RESULT.
//  - RESULT: result_valid=1 for exactly RESULT_CYC cycles.
//    At the end: if round==ROUNDS-1 -> DONE, else round += 1 -> LOAD_A.
//  - DONE: game_over=1, busy=0; score, round and correct hold. start -> LOAD_A (new game).
//  - busy=1 in LOAD_A..RESULT.
//  - start is ignored outside IDLE/DONE; enter is ignored outside WAIT_ANS.
//  - Latency: start pulse to load_a is 1 cycle; enter pulse to load_ans is 1 cycle;
//    load_ans to result_valid is 2 cycles.
// CONFIGURATION
//  ROUND_TIMEOUT_EN defined:
//    Answer timer is implemented; WAIT_ANS expires after TIMEOUT_CYC cycles.
//  ROUND_TIMEOUT_EN undefined:
//    No timer logic; WAIT_ANS waits for enter indefinitely; timed_out is tied to 0.
// TESTING
//  1 Reset: rst=0 for 2 cycles during WAIT_ANS -> IDLE next edge; all outputs 0; no load_* pulse.
//  2 Correct answer: a_q=3, b_q=4, enter, ans_q=7 -> load_ans 1 cycle after enter;
//    2 cycles later correct=1, score 0->1, result_valid high for 50 cycles.
//  3 Wrap and wrong: a_q=9, b_q=9, ans_q=2 -> correct=1 (18 mod 16);
//    ans_q=3 -> correct=0, score unchanged.
//  4 Full game: 8 rounds all correct -> round counts 0..7; DONE with score=8,
//    game_over=1; start restarts with score=0.
//  5 Saturation: SCORE_W=2, 5 correct rounds -> score stops at 3.
//  6 Timeout (ROUND_TIMEOUT_EN, TIMEOUT_CYC=10): no enter -> RESULT exactly 10 cycles
//    after entering WAIT_ANS with timed_out=1; enter on the expiry cycle -> load_ans wins.

Source files
------------

// File: rtl/math_round_sequencer_if.sv
// Handshake/bus bundle between the math-game round sequencer and its surroundings
// (buttons, operand/answer load registers, display logic).
interface math_round_sequencer_if #(
  parameter int DATA_W  = 4,
  parameter int SCORE_W = 4,
  parameter int ROUND_W = 3
);
  logic               start;
  logic               enter;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  ans_q;
  logic               load_a;
  logic               load_b;
  logic               load_ans;
  logic               result_valid;
  logic               correct;
  logic               timed_out;
  logic [SCORE_W-1:0] score;
  logic [ROUND_W-1:0] round;
  logic               busy;
  logic               game_over;

  modport master (
    output start, enter, a_q, b_q, ans_q,
    input  load_a, load_b, load_ans, result_valid, correct, timed_out,
           score, round, busy, game_over
  );

  modport slave (
    input  start, enter, a_q, b_q, ans_q,
    output load_a, load_b, load_ans, result_valid, correct, timed_out,
           score, round, busy, game_over
  );
endinterface

// File: rtl/math_round_sequencer.sv
// Round controller for the math game: sequences operand/answer loads, checks answers,
// keeps score and round count. Optional answer timer enabled by ROUND_TIMEOUT_EN.
module math_round_sequencer #(
  parameter int DATA_W      = 4,
  parameter int SCORE_W     = 4,
  parameter int ROUNDS      = 8,
  parameter int ROUND_W     = 3,
  parameter int RESULT_CYC  = 50,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                  clk,
  input logic                  rst,
  math_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT_ANS, S_LOAD_ANS, S_CHECK, S_RESULT, S_DONE
  } state_e;

  localparam int RES_W = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state_q, state_d;
  logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               correct_q, correct_d;
  logic               timed_out_q, timed_out_d;
  logic               load_a_q, load_a_d;
  logic               load_b_q, load_b_d;
  logic               load_ans_q, load_ans_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;
  logic [DATA_W-1:0]  sum_s;
  logic               expired_s;

  // The sum truncates to DATA_W bits, giving the mod 2**DATA_W answer rule.
  assign sum_s = bus.a_q + bus.b_q;

`ifdef ROUND_TIMEOUT_EN
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Answer timer: cleared on the way into WAIT_ANS, counts while waiting.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == S_LOAD_B) begin
      tmr_d = '0;
    end else if (state_q == S_WAIT_ANS && !expired_s) begin
      tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
    end else begin
      tmr_d = tmr_q;
    end
  end

  assign expired_s = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  // Timer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  logic [TMR_W-1:0] unused_tmr_s;
  assign unused_tmr_s = TMR_W'(TIMEOUT_CYC - 1);
  assign expired_s    = 1'b0;
`endif

  // Next-state and next-value logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    res_cnt_d   = res_cnt_q;
    round_d     = round_q;
    score_d     = score_q;
    correct_d   = correct_q;
    timed_out_d = timed_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_LOAD_A;
          score_d     = '0;
          round_d     = '0;
          correct_d   = 1'b0;
          timed_out_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD_A:   state_d = S_LOAD_B;
      S_LOAD_B:   state_d = S_WAIT_ANS;
      S_WAIT_ANS: begin
        // enter has priority over an expiry in the same cycle
        if (bus.enter) begin
          state_d = S_LOAD_ANS;
        end else if (expired_s) begin
          state_d     = S_RESULT;
          res_cnt_d   = '0;
          timed_out_d = 1'b1;
          correct_d   = 1'b0;
        end else begin
          state_d = S_WAIT_ANS;
        end
      end
      S_LOAD_ANS: state_d = S_CHECK;
      S_CHECK: begin
        correct_d   = (sum_s == bus.ans_q);
        timed_out_d = 1'b0;
        if ((sum_s == bus.ans_q) && (score_q != {SCORE_W{1'b1}})) begin
          score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
          score_d = score_q;
        end
        res_cnt_d = '0;
        state_d   = S_RESULT;
      end
      S_RESULT: begin
        if (res_cnt_q == RES_W'(RESULT_CYC - 1)) begin
          if (round_q == ROUND_W'(ROUNDS - 1)) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + {{(ROUND_W-1){1'b0}}, 1'b1};
            state_d = S_LOAD_A;
          end
        end else begin
          res_cnt_d = res_cnt_q + {{(RES_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_a_d       = (state_d == S_LOAD_A);
    load_b_d       = (state_d == S_LOAD_B);
    load_ans_d     = (state_d == S_LOAD_ANS);
    result_valid_d = (state_d == S_RESULT);
    game_over_d    = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs; reset aborts any round and suppresses strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      res_cnt_q      <= '0;
      round_q        <= '0;
      score_q        <= '0;
      correct_q      <= 1'b0;
      timed_out_q    <= 1'b0;
      load_a_q       <= 1'b0;
      load_b_q       <= 1'b0;
      load_ans_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      res_cnt_q      <= res_cnt_d;
      round_q        <= round_d;
      score_q        <= score_d;
      correct_q      <= correct_d;
      timed_out_q    <= timed_out_d;
      load_a_q       <= load_a_d;
      load_b_q       <= load_b_d;
      load_ans_q     <= load_ans_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.load_a       = load_a_q;
  assign bus.load_b       = load_b_q;
  assign bus.load_ans     = load_ans_q;
  assign bus.result_valid = result_valid_q;
  assign bus.correct      = correct_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.score        = score_q;
  assign bus.round        = round_q;
  assign bus.busy         = busy_q;
  assign bus.game_over    = game_over_q;

endmodule
